// File: rtl/sw_db_pkg.sv
// rtl/sw_db_pkg.sv - shared defaults and counter sizing for the switch debouncer
package sw_db_pkg;

    localparam int N_SW_DEF      = 3;
    localparam int DB_CYCLES_DEF = 1_000_000;

    // Wide enough to hold DB_CYCLES itself, so DB_CYCLES-1 never wraps.
    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch-in / debounced-out bundle; SW_EDGE_PULSE_EN adds sw_rise/sw_fall
interface sw_debounce_if
    import sw_db_pkg::*;
#(
    parameter int N_SW = N_SW_DEF
);
    logic [N_SW-1:0] sw;
    logic [N_SW-1:0] sw_db;
`ifdef SW_EDGE_PULSE_EN
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    modport master (output sw, input  sw_db, sw_rise, sw_fall);
    modport slave  (input  sw, output sw_db, sw_rise, sw_fall);
`else
    modport master (output sw, input  sw_db);
    modport slave  (input  sw, output sw_db);
`endif
endinterface

// File: rtl/sw_db_chan.sv
// rtl/sw_db_chan.sv - one debounce channel: 2-flop sync, stability counter; SW_EDGE_PULSE_EN adds edge pulses
module sw_db_chan
    import sw_db_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
`ifdef SW_EDGE_PULSE_EN
    output logic sw_rise,
    output logic sw_fall,
`endif
    output logic sw_db
);
    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          st;
    logic [CW-1:0] cnt;
    logic          commit;

    // The raw switch is asynchronous; nothing but s1 may look at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    assign commit = (s2 != st) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= 1'b0;
            cnt <= '0;
        end else if (s2 == st) begin
            cnt <= '0;
        end else if (commit) begin
            st  <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sw_db = st;

`ifdef SW_EDGE_PULSE_EN
    // Pulses are registered on the same edge as st, so they line up with the new sw_db level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sw_rise <= commit &&  s2;
            sw_fall <= commit && !s2;
        end
    end
`endif

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - N_SW independent switch debouncers; SW_EDGE_PULSE_EN adds sw_rise/sw_fall
module sw_debounce
    import sw_db_pkg::*;
#(
    parameter int N_SW      = N_SW_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_debounce_if.slave   bus
);
    logic [N_SW-1:0] db_v;
`ifdef SW_EDGE_PULSE_EN
    logic [N_SW-1:0] rise_v;
    logic [N_SW-1:0] fall_v;
`endif

    for (genvar i = 0; i < N_SW; i++) begin : g_chan
        sw_db_chan #(
            .DB_CYCLES (DB_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw      (bus.sw[i]),
`ifdef SW_EDGE_PULSE_EN
            .sw_rise (rise_v[i]),
            .sw_fall (fall_v[i]),
`endif
            .sw_db   (db_v[i])
        );
    end

    assign bus.sw_db   = db_v;
`ifdef SW_EDGE_PULSE_EN
    assign bus.sw_rise = rise_v;
    assign bus.sw_fall = fall_v;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - bench for sw_debounce (DB_CYCLES=4, N_SW=3), table vectors plus random vs window model
module tb_sw_debounce;
    localparam int NSW = 3;
    localparam int DB  = 4;
`ifdef SW_EDGE_PULSE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sw_debounce_if #(.N_SW(NSW)) bus ();

    sw_debounce #(
        .N_SW      (NSW),
        .DB_CYCLES (DB)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [2:0] sw;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    int         n_pass  = 0;
    int         n_total = 0;

    // Model: history of sampled sw levels; a channel flips when its last DB synchronized samples all differ from it.
    logic [2:0] samp_q[$];
    logic [2:0] m_st   = '0;
    logic [2:0] m_rise = '0;
    logic [2:0] m_fall = '0;

    function automatic logic [8:0] e(logic [2:0] d, logic [2:0] r, logic [2:0] f);
        return {d, r, f};
    endfunction

    function automatic logic [8:0] obs();
`ifdef SW_EDGE_PULSE_EN
        return {bus.sw_db, bus.sw_rise, bus.sw_fall};
`else
        return {bus.sw_db, 6'b0};
`endif
    endfunction

    function automatic logic [8:0] mask(logic [8:0] x);
        return EDGE_EN ? x : {x[8:6], 6'b0};
    endfunction

    task automatic check(string name, logic [8:0] exp);
        logic [8:0] got;
        logic [8:0] want;
        got  = obs();
        want = mask(exp);
        n_total++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got db/rise/fall=%b/%b/%b want %b/%b/%b",
                     name, got[8:6], got[5:3], got[2:0], want[8:6], want[5:3], want[2:0]);
    endtask

    function automatic logic [2:0] s2_at(int idx);
        if (idx < 0) return 3'b000;
        return samp_q[idx];
    endfunction

    task automatic model_edge();
        logic [2:0] v;
        bit         all_diff;
        if (!rst_n) begin
            samp_q.delete();
            m_st   = '0;
            m_rise = '0;
            m_fall = '0;
            return;
        end
        samp_q.push_back(bus.sw);
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < NSW; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                v = s2_at(samp_q.size() - 3 - j);
                if (v[ch] == m_st[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_st[ch] = ~m_st[ch];
                if (m_st[ch]) m_rise[ch] = 1'b1;
                else          m_fall[ch] = 1'b1;
            end
        end
        if (samp_q.size() > 32) void'(samp_q.pop_front());
    endtask

    task automatic step(logic r, logic [2:0] s);
        rst_n  = r;
        bus.sw = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply(string name, logic r, logic [2:0] s, logic [8:0] exp);
        step(r, s);
        check(name, exp);
    endtask

    task automatic add(logic r, logic [2:0] s, logic [8:0] exp, int n);
        vec_t v;
        v.rst = r;
        v.sw  = s;
        v.exp = exp;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] s;
        logic       r;
        logic [7:0] bounce;
        bus.sw = '0;

        // reset with switches high, then release
        add(1'b0, 3'b111, e(3'b000, 3'b000, 3'b000), 2);
        add(1'b1, 3'b111, e(3'b000, 3'b000, 3'b000), 5);
        add(1'b1, 3'b111, e(3'b111, 3'b111, 3'b000), 1);
        add(1'b1, 3'b111, e(3'b111, 3'b000, 3'b000), 1);
        // all fall
        add(1'b1, 3'b000, e(3'b111, 3'b000, 3'b000), 5);
        add(1'b1, 3'b000, e(3'b000, 3'b000, 3'b111), 1);
        add(1'b1, 3'b000, e(3'b000, 3'b000, 3'b000), 1);
        // clean step on sw[0]
        add(1'b1, 3'b001, e(3'b000, 3'b000, 3'b000), 5);
        add(1'b1, 3'b001, e(3'b001, 3'b001, 3'b000), 1);
        add(1'b1, 3'b001, e(3'b001, 3'b000, 3'b000), 1);
        add(1'b1, 3'b000, e(3'b001, 3'b000, 3'b000), 5);
        add(1'b1, 3'b000, e(3'b000, 3'b000, 3'b001), 1);
        add(1'b1, 3'b000, e(3'b000, 3'b000, 3'b000), 1);
        // simultaneous 000 -> 101
        add(1'b1, 3'b101, e(3'b000, 3'b000, 3'b000), 5);
        add(1'b1, 3'b101, e(3'b101, 3'b101, 3'b000), 1);
        add(1'b1, 3'b101, e(3'b101, 3'b000, 3'b000), 1);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("tbl%0d", i), vecs[i].rst, vecs[i].sw, vecs[i].exp);

        // bounce on sw[1]: 1,0,1,0 every 2 cycles, then hold 1
        bounce = 8'b00110011;
        for (int k = 0; k < 8; k++)
            apply($sformatf("bounce%0d", k), 1'b1, {1'b1, bounce[k], 1'b1}, e(3'b101, 3'b000, 3'b000));
        for (int k = 0; k < 5; k++)
            apply($sformatf("bhold%0d", k), 1'b1, 3'b111, e(3'b101, 3'b000, 3'b000));
        apply("bhold_edge6", 1'b1, 3'b111, e(3'b111, 3'b010, 3'b000));
        apply("bhold_after", 1'b1, 3'b111, e(3'b111, 3'b000, 3'b000));

        // late glitch on sw[2]: bring it low, then 3 high samples, then low
        for (int k = 0; k < 5; k++)
            apply($sformatf("g_low%0d", k), 1'b1, 3'b011, e(3'b111, 3'b000, 3'b000));
        apply("g_low_edge6", 1'b1, 3'b011, e(3'b011, 3'b000, 3'b100));
        apply("g_low_after", 1'b1, 3'b011, e(3'b011, 3'b000, 3'b000));
        for (int k = 0; k < 3; k++)
            apply($sformatf("glitch%0d", k), 1'b1, 3'b111, e(3'b011, 3'b000, 3'b000));
        for (int k = 0; k < 6; k++)
            apply($sformatf("g_ret%0d", k), 1'b1, 3'b011, e(3'b011, 3'b000, 3'b000));
        // a fresh hold must need the full latency, so the glitch left cnt at 0
        for (int k = 0; k < 5; k++)
            apply($sformatf("g_hold%0d", k), 1'b1, 3'b111, e(3'b011, 3'b000, 3'b000));
        apply("g_hold_edge6", 1'b1, 3'b111, e(3'b111, 3'b100, 3'b000));

        // reset mid-count on sw[0]
        apply("mr_rst0", 1'b0, 3'b000, e(3'b000, 3'b000, 3'b000));
        apply("mr_rst1", 1'b0, 3'b000, e(3'b000, 3'b000, 3'b000));
        apply("mr_idle0", 1'b1, 3'b000, e(3'b000, 3'b000, 3'b000));
        apply("mr_idle1", 1'b1, 3'b000, e(3'b000, 3'b000, 3'b000));
        for (int k = 0; k < 5; k++)
            apply($sformatf("mr_cnt%0d", k), 1'b1, 3'b001, e(3'b000, 3'b000, 3'b000));
        rst_n = 1'b0;
        #1;
        check("mr_async", e(3'b000, 3'b000, 3'b000));
        apply("mr_held", 1'b0, 3'b001, e(3'b000, 3'b000, 3'b000));
        for (int k = 0; k < 5; k++)
            apply($sformatf("mr_rel%0d", k), 1'b1, 3'b001, e(3'b000, 3'b000, 3'b000));
        apply("mr_edge6", 1'b1, 3'b001, e(3'b001, 3'b001, 3'b000));
        apply("mr_after", 1'b1, 3'b001, e(3'b001, 3'b000, 3'b000));

        // random toggling against the window model
        for (int n = 0; n < 600; n++) begin
            s = bus.sw;
            for (int ch = 0; ch < NSW; ch++)
                if ($urandom_range(0, 5) == 0) s[ch] = ~s[ch];
            r = ($urandom_range(0, 199) != 0);
            step(r, s);
            check($sformatf("rand%0d", n), {m_st, m_rise, m_fall});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter N_SW, default 3: number of independent switch channels, legal range 1..16.
REQ-003 Parameter DB_CYCLES, default 1_000_000 (10 ms at 100 MHz): required stable cycles before an output change, legal range 1..2^20.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sw  input  N_SW  raw board switch levels, asynchronous to clk, may bounce.
REQ-007 sw_db  output  N_SW  debounced, synchronized levels, registered; these feed the downstream full-adder inputs (bit 0 = a, bit 1 = b, bit 2 = cin).
REQ-008 sw_rise  output  N_SW  one-cycle pulse per channel on a debounced 0->1 change (present only under SW_EDGE_PULSE_EN).
REQ-009 sw_fall  output  N_SW  one-cycle pulse per channel on a debounced 1->0 change (present only under SW_EDGE_PULSE_EN).

Function
REQ-010 Each channel SHALL pass sw[i] through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 Each channel SHALL hold a counter cnt of width $clog2(DB_CYCLES+1) and a stable register st driving sw_db[i].
REQ-012 Each edge with s2 == st: cnt <= 0, st unchanged.
REQ-013 Each edge with s2 != st and cnt < DB_CYCLES-1: cnt <= cnt+1.
REQ-014 Each edge with s2 != st and cnt == DB_CYCLES-1: st <= s2, cnt <= 0.
REQ-015 Latency: a level held on sw SHALL appear on sw_db at rising edge DB_CYCLES+2, counting the first edge that samples the new level as edge 1.
REQ-016 A glitch whose s2 duration is shorter than DB_CYCLES cycles SHALL leave sw_db unchanged and clear cnt on return.
REQ-017 An input returning to st exactly when cnt == DB_CYCLES-1 SHALL not update st; cnt clears.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-012..014 with no interaction.
REQ-019 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-020 Per channel state is two-valued (STABLE: cnt == 0 and s2 == st; PENDING: counting); no other FSM exists.

Reset
REQ-021 While rst_n is low: s1, s2, st, cnt, sw_db, sw_rise, sw_fall SHALL all be 0.
REQ-022 After release, a switch already high SHALL produce sw_db = 1 at edge DB_CYCLES+2 after release, with an sw_rise pulse when enabled.
REQ-023 Assertion of rst_n mid-count SHALL discard progress immediately; no partial count survives.

Configuration
REQ-024 Macro SW_EDGE_PULSE_EN defined: sw_rise/sw_fall ports exist; sw_rise[i] (sw_fall[i]) SHALL be high for exactly the one cycle in which sw_db[i] first shows 1 (0), registered on the same edge that updates st.
REQ-025 Macro SW_EDGE_PULSE_EN undefined: sw_rise/sw_fall ports and logic SHALL be absent; sw_db behaviour identical.

Structure
REQ-026 Package sw_db_pkg SHALL hold N_SW_DEF = 3, DB_CYCLES_DEF = 1_000_000, and a function returning the counter width.
REQ-027 Sub-module sw_db_chan SHALL implement one channel (synchronizer, counter, st, edge pulses); sw_debounce instantiates it N_SW times via generate.

Verification (DB_CYCLES = 4, N_SW = 3)
REQ-028 Reset: rst_n = 0 with sw = 3'b111 -> all outputs 0; release -> sw_db = 3'b111 at edge 6, one-cycle sw_rise = 3'b111 in the same cycle.
REQ-029 Clean step: sw[0] 0->1 held -> sw_db[0] = 1 exactly at edge 6; sw_rise[0] high one cycle; sw_fall stays 0.
REQ-030 Bounce: sw[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> sw_db[1] rises only at edge 6 after the final stable sample; no intermediate pulses.
REQ-031 Late glitch: sw[2] high for exactly 3 sampled cycles, then low -> sw_db[2] stays 0, cnt returns to 0.
REQ-032 Simultaneous: sw 3'b000 -> 3'b101 -> sw_db = 3'b101 on the same edge; sw_rise = 3'b101 for one cycle.
REQ-033 Reset mid-count: rst_n pulsed low when cnt = 3 -> sw_db stays 0; after release the full 6-edge latency restarts.
